// File: rtl/rx_ipv4_filter.sv
// ---------------------------------------------------------------------------------------------
// rx_ipv4_filter
//
// IPv4 receive parser. Consumes one IPv4 frame per rx_payload_ipv4 burst, parses the header
// (including IHL options), verifies version/IHL/length, header checksum, destination address
// and fragmentation. It then steers exactly total_len - IHL*4 payload bytes to one of PROTO_NUM
// L4 channels. Bytes after the IPv4 payload (Ethernet padding, FCS remnants) are discarded.
// Every rejected packet produces one rx_pkt_drop pulse with a reason code.
//
// Ports
//   RX_CLK           receive clock, all logic on posedge
//   rst_n            synchronous active-low reset
//   ip_addr          local IPv4 address, compared when the header completes
//   rx_payload_ipv4  byte-valid for the IPv4 frame; falling level marks frame end
//   rx_payload       IPv4 byte stream, network order
//   rx_src_ip        source address of the last accepted packet
//   rx_dst_ip        destination address of the last accepted packet
//   rx_protocol      protocol byte of the last accepted packet
//   rx_pay_len       total_len - IHL*4 of the last accepted packet
//   rx_hdr_ok        1-cycle pulse, header accepted
//   rx_data_valid    one-hot channel strobe for rx_data
//   rx_data          payload byte
//   rx_data_last     high with the final payload byte
//   rx_pkt_drop      1-cycle pulse, packet rejected
//   rx_drop_code     reject reason while rx_pkt_drop is high
//                    1 format, 2 checksum, 3 address, 4 fragment, 5 protocol, 6 truncated
// ---------------------------------------------------------------------------------------------
module rx_ipv4_filter #(
    parameter int unsigned            OCT          = 8,
    parameter int unsigned            PROTO_NUM    = 2,
    parameter logic [PROTO_NUM*8-1:0] PROTO_LIST   = {8'h06, 8'h11},
    parameter bit                     ACCEPT_BCAST = 1'b1
) (
    input  logic                 RX_CLK,
    input  logic                 rst_n,
    input  logic [31:0]          ip_addr,
    input  logic                 rx_payload_ipv4,
    input  logic [OCT-1:0]       rx_payload,
    output logic [31:0]          rx_src_ip,
    output logic [31:0]          rx_dst_ip,
    output logic [7:0]           rx_protocol,
    output logic [15:0]          rx_pay_len,
    output logic                 rx_hdr_ok,
    output logic [PROTO_NUM-1:0] rx_data_valid,
    output logic [OCT-1:0]       rx_data,
    output logic                 rx_data_last,
    output logic                 rx_pkt_drop,
    output logic [2:0]           rx_drop_code
);

    localparam int unsigned ChW = (PROTO_NUM > 1) ? $clog2(PROTO_NUM) : 1;

    localparam logic [2:0] DropNone   = 3'd0;
    localparam logic [2:0] DropFormat = 3'd1;
    localparam logic [2:0] DropCsum   = 3'd2;
    localparam logic [2:0] DropAddr   = 3'd3;
    localparam logic [2:0] DropFrag   = 3'd4;
    localparam logic [2:0] DropProto  = 3'd5;
    localparam logic [2:0] DropTrunc  = 3'd6;

    typedef enum logic [2:0] {
        StHdr,
        StOpt,
        StData,
        StPad,
        StWait
    } state_e;

    // Control state
    state_e         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;        // header byte index, 0..59
    logic           armed_q, armed_d;    // a frame start may be parsed
    logic [15:0]    remain_q, remain_d;  // payload bytes still to forward
    logic [ChW-1:0] ch_q, ch_d;

    // Header working registers
    logic [7:0]     b0_q, b0_d;          // {version, IHL}
    logic [15:0]    tot_len_q, tot_len_d;
    logic [13:0]    frag_q, frag_d;      // {MF, fragment offset}
    logic [7:0]     proto_q, proto_d;
    logic [31:0]    src_q, src_d;
    logic [31:0]    dst_q, dst_d;
    logic [7:0]     hi_q, hi_d;          // high byte of the header word in progress
    logic [15:0]    csum_q, csum_d;      // folded one's-complement sum

    // Output next-state
    logic [31:0]          src_ip_d, dst_ip_d;
    logic [7:0]           protocol_d;
    logic [15:0]          pay_len_d;
    logic                 hdr_ok_d, data_last_d, pkt_drop_d;
    logic [PROTO_NUM-1:0] data_valid_d;
    logic [OCT-1:0]       data_d;
    logic [2:0]           drop_code_d;

    // Decode helpers
    logic           hdr_byte;
    logic [16:0]    sum_raw;
    logic [15:0]    sum_fold;
    logic [3:0]     ihl;
    logic [5:0]     hdr_bytes;
    logic [5:0]     last_idx;
    logic [15:0]    hdr_len16;
    logic [15:0]    pay_len_calc;
    logic           is_last_hdr;
    logic           addr_ok;
    logic           proto_hit;
    logic [ChW-1:0] proto_idx;
    logic [2:0]     check_code;

    assign hdr_byte = rx_payload_ipv4 && armed_q && (state_q == StHdr || state_q == StOpt);

    // End-around carry: the 17-bit raw sum never exceeds 1FFFE, so one fold is enough.
    assign sum_raw  = {1'b0, csum_q} + {1'b0, hi_q, rx_payload};
    assign sum_fold = sum_raw[15:0] + {15'd0, sum_raw[16]};

    // ------------------------------------------------------------------------------------------
    // Header shift-in and checksum accumulation
    // ------------------------------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        b0_d      = b0_q;
        tot_len_d = tot_len_q;
        frag_d    = frag_q;
        proto_d   = proto_q;
        src_d     = src_q;
        dst_d     = dst_q;
        hi_d      = hi_q;
        csum_d    = csum_q;

        if (!rx_payload_ipv4) begin
            cnt_d  = '0;
            csum_d = '0;
        end else if (hdr_byte) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd0) begin
                b0_d = rx_payload;
            end
            if (cnt_q == 6'd2 || cnt_q == 6'd3) begin
                tot_len_d = {tot_len_q[7:0], rx_payload};
            end
            if (cnt_q == 6'd6) begin
                frag_d[13:8] = rx_payload[5:0];
            end
            if (cnt_q == 6'd7) begin
                frag_d[7:0] = rx_payload;
            end
            if (cnt_q == 6'd9) begin
                proto_d = rx_payload;
            end
            if (cnt_q >= 6'd12 && cnt_q <= 6'd15) begin
                src_d = {src_q[23:0], rx_payload};
            end
            if (cnt_q >= 6'd16 && cnt_q <= 6'd19) begin
                dst_d = {dst_q[23:0], rx_payload};
            end
            if (cnt_q[0]) begin
                csum_d = sum_fold;
            end else begin
                hi_d = rx_payload;
            end
        end
    end

    // ------------------------------------------------------------------------------------------
    // Header checks; the _d field values already include the byte on the input this cycle
    // ------------------------------------------------------------------------------------------
    always_comb begin
        ihl       = b0_q[3:0];
        hdr_bytes = {ihl, 2'b00};
        // A short IHL is still evaluated after the fixed 20-byte header.
        last_idx  = (ihl < 4'd5) ? 6'd19 : hdr_bytes - 6'd1;
        hdr_len16 = {10'd0, hdr_bytes};
        pay_len_calc = tot_len_d - hdr_len16;
        is_last_hdr  = (cnt_q >= 6'd19) && (cnt_q == last_idx);

        addr_ok = (dst_d == ip_addr) || (ACCEPT_BCAST && (dst_d == 32'hFFFF_FFFF));

        proto_hit = 1'b0;
        proto_idx = '0;
        for (int i = 0; i < int'(PROTO_NUM); i++) begin
            if (!proto_hit && (proto_d == PROTO_LIST[8*i +: 8])) begin
                proto_hit = 1'b1;
                proto_idx = ChW'(i);
            end
        end

        // First failing check wins
        if (b0_q[7:4] != 4'd4 || ihl < 4'd5 || tot_len_d < hdr_len16) begin
            check_code = DropFormat;
        end else if (sum_fold != 16'hFFFF) begin
            check_code = DropCsum;
        end else if (!addr_ok) begin
            check_code = DropAddr;
        end else if (frag_d != 14'd0) begin
            check_code = DropFrag;
        end else if (!proto_hit) begin
            check_code = DropProto;
        end else begin
            check_code = DropNone;
        end
    end

    // ------------------------------------------------------------------------------------------
    // FSM next-state and registered outputs
    // ------------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        remain_d     = remain_q;
        ch_d         = ch_q;
        src_ip_d     = rx_src_ip;
        dst_ip_d     = rx_dst_ip;
        protocol_d   = rx_protocol;
        pay_len_d    = rx_pay_len;
        data_d       = rx_data;
        hdr_ok_d     = 1'b0;
        data_valid_d = '0;
        data_last_d  = 1'b0;
        pkt_drop_d   = 1'b0;
        drop_code_d  = DropNone;

        if (!rx_payload_ipv4) begin
            state_d  = StHdr;
            remain_d = '0;
            armed_d  = 1'b1;
            // Frame ended early: inside the header, or before all payload bytes arrived.
            if (armed_q && ((((state_q == StHdr) || (state_q == StOpt)) && (cnt_q != 6'd0)) ||
                            ((state_q == StData) && (remain_q != 16'd0)))) begin
                pkt_drop_d  = 1'b1;
                drop_code_d = DropTrunc;
            end
        end else if (armed_q) begin
            unique case (state_q)
                StHdr, StOpt: begin
                    if (is_last_hdr) begin
                        if (check_code != DropNone) begin
                            pkt_drop_d  = 1'b1;
                            drop_code_d = check_code;
                            state_d     = StWait;
                        end else begin
                            hdr_ok_d   = 1'b1;
                            src_ip_d   = src_d;
                            dst_ip_d   = dst_d;
                            protocol_d = proto_d;
                            pay_len_d  = pay_len_calc;
                            ch_d       = proto_idx;
                            remain_d   = pay_len_calc;
                            state_d    = (pay_len_calc == 16'd0) ? StPad : StData;
                        end
                    end else if (state_q == StHdr && cnt_q == 6'd19) begin
                        state_d = StOpt;
                    end
                end
                StData: begin
                    data_d             = rx_payload;
                    data_valid_d[ch_q] = 1'b1;
                    remain_d           = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        data_last_d = 1'b1;
                        state_d     = StPad;
                    end
                end
                StPad, StWait: begin
                end
                default: begin
                    state_d = StWait;
                end
            endcase
        end
    end

    always_ff @(posedge RX_CLK) begin
        if (!rst_n) begin
            state_q       <= StHdr;
            cnt_q         <= '0;
            // Reset inside a frame leaves the rest of that frame unparsed.
            armed_q       <= ~rx_payload_ipv4;
            remain_q      <= '0;
            ch_q          <= '0;
            b0_q          <= '0;
            tot_len_q     <= '0;
            frag_q        <= '0;
            proto_q       <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            hi_q          <= '0;
            csum_q        <= '0;
            rx_src_ip     <= '0;
            rx_dst_ip     <= '0;
            rx_protocol   <= '0;
            rx_pay_len    <= '0;
            rx_hdr_ok     <= 1'b0;
            rx_data_valid <= '0;
            rx_data       <= '0;
            rx_data_last  <= 1'b0;
            rx_pkt_drop   <= 1'b0;
            rx_drop_code  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            remain_q      <= remain_d;
            ch_q          <= ch_d;
            b0_q          <= b0_d;
            tot_len_q     <= tot_len_d;
            frag_q        <= frag_d;
            proto_q       <= proto_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            hi_q          <= hi_d;
            csum_q        <= csum_d;
            rx_src_ip     <= src_ip_d;
            rx_dst_ip     <= dst_ip_d;
            rx_protocol   <= protocol_d;
            rx_pay_len    <= pay_len_d;
            rx_hdr_ok     <= hdr_ok_d;
            rx_data_valid <= data_valid_d;
            rx_data       <= data_d;
            rx_data_last  <= data_last_d;
            rx_pkt_drop   <= pkt_drop_d;
            rx_drop_code  <= drop_code_d;
        end
    end

endmodule

// File: tb/tb_rx_ipv4_filter.sv
// ---------------------------------------------------------------------------------------------
// tb_rx_ipv4_filter
//
// Directed bench for rx_ipv4_filter. A table of packet descriptions with hand-chosen expected
// outcomes is built into byte frames (with the header checksum computed by the bench), sent,
// and the collected outputs compared. Hand-written sequences cover truncation followed by a
// back-to-back frame, and a reset in the middle of a payload.
// ---------------------------------------------------------------------------------------------
module tb_rx_ipv4_filter;

    localparam logic [31:0] LocalIp = 32'hC0A8_010A;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ip_addr;
    logic        rx_payload_ipv4;
    logic [7:0]  rx_payload;
    logic [31:0] rx_src_ip;
    logic [31:0] rx_dst_ip;
    logic [7:0]  rx_protocol;
    logic [15:0] rx_pay_len;
    logic        rx_hdr_ok;
    logic [1:0]  rx_data_valid;
    logic [7:0]  rx_data;
    logic        rx_data_last;
    logic        rx_pkt_drop;
    logic [2:0]  rx_drop_code;

    always #5 clk = ~clk;

    rx_ipv4_filter #(
        .OCT          (8),
        .PROTO_NUM    (2),
        .PROTO_LIST   ({8'h06, 8'h11}),
        .ACCEPT_BCAST (1'b1)
    ) dut (
        .RX_CLK          (clk),
        .rst_n           (rst_n),
        .ip_addr         (ip_addr),
        .rx_payload_ipv4 (rx_payload_ipv4),
        .rx_payload      (rx_payload),
        .rx_src_ip       (rx_src_ip),
        .rx_dst_ip       (rx_dst_ip),
        .rx_protocol     (rx_protocol),
        .rx_pay_len      (rx_pay_len),
        .rx_hdr_ok       (rx_hdr_ok),
        .rx_data_valid   (rx_data_valid),
        .rx_data         (rx_data),
        .rx_data_last    (rx_data_last),
        .rx_pkt_drop     (rx_pkt_drop),
        .rx_drop_code    (rx_drop_code)
    );

    typedef struct {
        logic [3:0]  ver;
        logic [3:0]  ihl;
        logic [15:0] tot_len;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] dst;
        logic        flip;       // corrupt checksum by one
        int          frame_len;  // bytes actually sent
        int          exp_code;   // 0 = accepted
        logic [1:0]  exp_valid;
    } vec_t;

    localparam int NVec = 15;
    vec_t vecs [NVec];

    logic [7:0] frame [64];

    int n_checks = 0;
    int n_fail   = 0;

    // Output monitor
    logic [7:0] got_data [$];
    logic [1:0] got_valid [$];
    int         n_hdr_ok, n_drop, n_last, last_pos, stray_last;
    logic [2:0] last_code;

    always @(negedge clk) begin
        if (rst_n === 1'b1 || rst_n === 1'b0) begin
            if (rx_hdr_ok === 1'b1) n_hdr_ok++;
            if (rx_pkt_drop === 1'b1) begin
                n_drop++;
                last_code = rx_drop_code;
            end
            if (rx_data_valid !== 2'b00 && rx_data_valid !== 2'bxx) begin
                got_data.push_back(rx_data);
                got_valid.push_back(rx_data_valid);
                if (rx_data_last === 1'b1) begin
                    n_last++;
                    last_pos = got_data.size();
                end
            end else if (rx_data_last === 1'b1) begin
                stray_last++;
            end
        end
    end

    task automatic clear_mon();
        got_data.delete();
        got_valid.delete();
        n_hdr_ok   = 0;
        n_drop     = 0;
        n_last     = 0;
        last_pos   = 0;
        stray_last = 0;
        last_code  = 3'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int hdr_len(input vec_t v);
        return (v.ihl < 4'd5) ? 20 : int'(v.ihl) * 4;
    endfunction

    task automatic build(input vec_t v, input logic [31:0] src);
        int          hlen;
        int unsigned s;
        logic [15:0] cs;
        hlen = hdr_len(v);
        for (int k = 0; k < 64; k++) frame[k] = 8'hEE;
        frame[0]  = {v.ver, v.ihl};
        frame[1]  = 8'h00;
        frame[2]  = v.tot_len[15:8];
        frame[3]  = v.tot_len[7:0];
        frame[4]  = 8'h12;
        frame[5]  = 8'h34;
        frame[6]  = v.frag[15:8];
        frame[7]  = v.frag[7:0];
        frame[8]  = 8'h40;
        frame[9]  = v.proto;
        frame[10] = 8'h00;
        frame[11] = 8'h00;
        frame[12] = src[31:24];
        frame[13] = src[23:16];
        frame[14] = src[15:8];
        frame[15] = src[7:0];
        frame[16] = v.dst[31:24];
        frame[17] = v.dst[23:16];
        frame[18] = v.dst[15:8];
        frame[19] = v.dst[7:0];
        for (int k = 20; k < hlen; k++) frame[k] = 8'hA0 + 8'(k);
        for (int k = hlen; k < int'(v.tot_len) && k < 64; k++) frame[k] = 8'(k - hlen);
        s = 0;
        for (int k = 0; k < hlen; k += 2) begin
            s = s + {16'd0, frame[k], frame[k+1]};
            s = (s & 32'h0000_FFFF) + (s >> 16);
        end
        cs = ~(16'(s));
        if (v.flip) cs = cs ^ 16'h0001;
        frame[10] = cs[15:8];
        frame[11] = cs[7:0];
    endtask

    task automatic drive_bytes(input int from, input int to);
        for (int k = from; k < to; k++) begin
            @(negedge clk);
            rx_payload_ipv4 = 1'b1;
            rx_payload      = frame[k];
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
    endtask

    initial begin
        int    exp_n;
        int    hlen;
        string nm;

        //                 ver   ihl   tot_len  frag      proto  dst            flip len code valid
        vecs[0]  = '{4'd4, 4'd5, 16'h0020, 16'h0000, 8'h11, LocalIp,       1'b0, 32, 0, 2'b01};
        vecs[1]  = '{4'd4, 4'd6, 16'h001C, 16'h0000, 8'h06, LocalIp,       1'b0, 28, 0, 2'b10};
        vecs[2]  = '{4'd4, 4'd5, 16'h001C, 16'h0000, 8'h11, LocalIp,       1'b0, 46, 0, 2'b01};
        vecs[3]  = '{4'd4, 4'd5, 16'h0020, 16'h0000, 8'h11, LocalIp,       1'b1, 32, 2, 2'b00};
        vecs[4]  = '{4'd4, 4'd5, 16'h0020, 16'h0000, 8'h11, 32'hC0A8010B, 1'b0, 32, 3, 2'b00};
        vecs[5]  = '{4'd4, 4'd5, 16'h0020, 16'h2000, 8'h11, LocalIp,       1'b0, 32, 4, 2'b00};
        vecs[6]  = '{4'd4, 4'd5, 16'h0020, 16'h0000, 8'h01, LocalIp,       1'b0, 32, 5, 2'b00};
        vecs[7]  = '{4'd4, 4'd5, 16'h0020, 16'h0000, 8'h11, 32'hFFFFFFFF, 1'b0, 32, 0, 2'b01};
        vecs[8]  = '{4'd6, 4'd5, 16'h0020, 16'h0000, 8'h11, LocalIp,       1'b0, 32, 1, 2'b00};
        vecs[9]  = '{4'd4, 4'd5, 16'h0010, 16'h0000, 8'h11, LocalIp,       1'b0, 32, 1, 2'b00};
        vecs[10] = '{4'd4, 4'd5, 16'h0020, 16'h0001, 8'h11, LocalIp,       1'b0, 32, 4, 2'b00};
        vecs[11] = '{4'd4, 4'd5, 16'h0018, 16'h4000, 8'h06, LocalIp,       1'b0, 24, 0, 2'b10};
        vecs[12] = '{4'd4, 4'd4, 16'h0020, 16'h0000, 8'h11, LocalIp,       1'b0, 32, 1, 2'b00};
        vecs[13] = '{4'd4, 4'd5, 16'h0014, 16'h0000, 8'h11, LocalIp,       1'b0, 30, 0, 2'b01};
        vecs[14] = '{4'd4, 4'd7, 16'h0024, 16'h0000, 8'h11, 32'hC0A8010B, 1'b0, 36, 3, 2'b00};

        rst_n           = 1'b0;
        ip_addr         = LocalIp;
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
        clear_mon();
        repeat (3) @(negedge clk);

        check("reset src_ip",     rx_src_ip, 32'h0);
        check("reset dst_ip",     rx_dst_ip, 32'h0);
        check("reset protocol",   {24'd0, rx_protocol}, 32'h0);
        check("reset pay_len",    {16'd0, rx_pay_len}, 32'h0);
        check("reset pulses",     {26'd0, rx_hdr_ok, rx_data_valid, rx_data_last, rx_pkt_drop,
                                   1'b0}, 32'h0);
        check("reset drop_code",  {29'd0, rx_drop_code}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven packets
        for (int i = 0; i < NVec; i++) begin
            clear_mon();
            build(vecs[i], 32'h0A00_0000 + 32'(i));
            drive_bytes(0, vecs[i].frame_len);
            end_frame();
            repeat (3) @(negedge clk);
            hlen  = hdr_len(vecs[i]);
            exp_n = (vecs[i].exp_code == 0) ? int'(vecs[i].tot_len) - hlen : 0;

            check($sformatf("v%0d hdr_ok count", i), n_hdr_ok, (vecs[i].exp_code == 0) ? 1 : 0);
            check($sformatf("v%0d drop count", i), n_drop, (vecs[i].exp_code == 0) ? 0 : 1);
            check($sformatf("v%0d data count", i), got_data.size(), exp_n);
            check($sformatf("v%0d last count", i), n_last + stray_last, (exp_n > 0) ? 1 : 0);
            if (vecs[i].exp_code != 0) begin
                check($sformatf("v%0d drop code", i), {29'd0, last_code}, vecs[i].exp_code);
            end else begin
                check($sformatf("v%0d pay_len", i), {16'd0, rx_pay_len}, exp_n);
                check($sformatf("v%0d src_ip", i), rx_src_ip, 32'h0A00_0000 + 32'(i));
                check($sformatf("v%0d dst_ip", i), rx_dst_ip, vecs[i].dst);
                check($sformatf("v%0d protocol", i), {24'd0, rx_protocol}, {24'd0, vecs[i].proto});
                if (exp_n > 0) check($sformatf("v%0d last pos", i), last_pos, exp_n);
                for (int k = 0; k < exp_n && k < got_data.size(); k++) begin
                    nm = $sformatf("v%0d data[%0d]", i, k);
                    check(nm, {22'd0, got_valid[k], got_data[k]},
                          {22'd0, vecs[i].exp_valid, 8'(k)});
                end
            end
            @(negedge clk);
        end

        // Truncation after 5 of 12 payload bytes, one idle cycle, then a good frame
        clear_mon();
        build(vecs[0], 32'h0A00_00F0);
        drive_bytes(0, 25);
        end_frame();
        drive_bytes(0, 32);
        end_frame();
        repeat (3) @(negedge clk);
        check("trunc hdr_ok count", n_hdr_ok, 2);
        check("trunc drop count", n_drop, 1);
        check("trunc drop code", {29'd0, last_code}, 6);
        check("trunc last count", n_last + stray_last, 1);
        check("trunc data count", got_data.size(), 17);
        check("trunc last pos", last_pos, 17);
        for (int k = 0; k < 17 && k < got_data.size(); k++) begin
            check($sformatf("trunc data[%0d]", k), {24'd0, got_data[k]},
                  (k < 5) ? k : k - 5);
        end

        // Reset for one cycle after 3 payload bytes; remainder of that frame must be ignored
        @(negedge clk);
        clear_mon();
        build(vecs[0], 32'h0A00_00AA);
        drive_bytes(0, 23);
        @(negedge clk);
        rx_payload_ipv4 = 1'b1;
        rx_payload      = frame[23];
        rst_n           = 1'b0;
        @(negedge clk);
        check("midreset src_ip", rx_src_ip, 32'h0);
        check("midreset pay_len", {16'd0, rx_pay_len}, 32'h0);
        check("midreset pulses", {27'd0, rx_hdr_ok, rx_data_valid, rx_data_last, rx_pkt_drop},
              32'h0);
        rst_n      = 1'b1;
        rx_payload = frame[24];
        drive_bytes(25, 32);
        end_frame();
        repeat (3) @(negedge clk);
        check("midreset data count", got_data.size(), 3);
        check("midreset drop count", n_drop, 0);
        check("midreset last count", n_last + stray_last, 0);

        clear_mon();
        build(vecs[0], 32'h0A00_00BB);
        drive_bytes(0, 32);
        end_frame();
        repeat (3) @(negedge clk);
        check("postreset hdr_ok count", n_hdr_ok, 1);
        check("postreset data count", got_data.size(), 12);
        check("postreset last count", n_last, 1);
        check("postreset drop count", n_drop, 0);
        check("postreset src_ip", rx_src_ip, 32'h0A00_00BB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_ipv4_filter.md
Name: rx_ipv4_filter

Overview:
Parametrised IPv4 receive parser; next generation of the single-protocol IPv4 RX block. Sits between the Ethernet RX MAC/type demux and the L4 receivers (UDP, TCP, ...). Parses the header, including IHL options, and verifies the header checksum, destination address and fragmentation. It then steers exactly total_len − IHL·4 payload bytes to one of PROTO_NUM protocol channels, discarding Ethernet padding and reporting every drop with a reason code.

Parameters:
OCT, 8, bits per stream byte; fixed at 8 for this generation.
PROTO_NUM, 2, number of L4 output channels.
PROTO_LIST, {8'h06, 8'h11}, PROTO_NUM×8 packed protocol numbers; channel i = bits [8i+7:8i]. Defaults: ch0 = UDP, ch1 = TCP.
ACCEPT_BCAST, 1, 1 = also accept dst 255.255.255.255.

Ports:
RX_CLK  in  1  receive clock; all logic on posedge.
rst_n  in  1  reset; synchronous, active-low.
ip_addr  in  32  local IPv4 address; sampled when the header completes.
rx_payload_ipv4  in  1  high for each valid byte of one IPv4 frame; contiguous; the low level marks frame end.
rx_payload  in  8  IPv4 byte stream, network order.
rx_src_ip  out  32  captured source IP.
rx_dst_ip  out  32  captured destination IP.
rx_protocol  out  8  captured protocol byte.
rx_pay_len  out  16  total_len − IHL·4 of the accepted packet.
rx_hdr_ok  out  1  1-cycle pulse: header accepted.
rx_data_valid  out  PROTO_NUM  one-hot channel strobe for rx_data.
rx_data  out  8  payload byte.
rx_data_last  out  1  high with the final payload byte.
rx_pkt_drop  out  1  1-cycle pulse: packet rejected.
rx_drop_code  out  3  reason; valid while rx_pkt_drop is high.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, state HDR, all counters 0. Reset mid-packet aborts the packet silently: no drop pulse and no further data until the next frame start.
- States:
  - HDR: bytes 0–19.
  - OPT: bytes 20 to IHL·4−1.
  - DATA.
  - PAD: discard.
  - WAIT: discard until rx_payload_ipv4 falls.
- Any state, rx_payload_ipv4=0: next state is HDR, counters cleared. Header field registers hold their values.
- Header capture:
  - byte 0 = {version[7:4], IHL[3:0]}.
  - bytes 2–3 = total_len.
  - bytes 6–7 = flags/fragment offset.
  - byte 9 = protocol.
  - bytes 12–15 = src; bytes 16–19 = dst.
  - All fields big-endian, shift-in.
- Checksum: 17-bit one's-complement accumulator. Even bytes form the high half of each 16-bit word, odd bytes the low half. Every header word including options is added, with end-around carry folded. The header is valid iff the folded sum equals 16'hFFFF.
- Decision on the last header byte (byte IHL·4−1). The last byte is included combinationally. First failing check wins:
  1. version≠4, IHL<5, or total_len<IHL·4.
  2. checksum bad.
  3. dst≠ip_addr and not (ACCEPT_BCAST and dst=FFFFFFFF).
  4. MF=1 or fragment offset≠0.
  5. protocol not in PROTO_LIST.
  6. Truncation (see below).
- If IHL<5 is detected at byte 0, the packet is still evaluated at byte 19.
- On failure: next cycle rx_pkt_drop=1 with the code above; state WAIT.
- On success: next cycle rx_hdr_ok=1 and rx_src_ip/rx_dst_ip/rx_protocol/rx_pay_len are updated; the channel index is latched.
  - rx_pay_len=0: go to PAD.
  - Otherwise go to DATA with remaining = rx_pay_len.
- DATA: each input byte appears one cycle later on rx_data, with rx_data_valid[ch]=1 and the other channel bits 0. remaining decrements per byte. On the byte where remaining=1, rx_data_last=1 and the next state is PAD.
- PAD: input bytes are ignored. This covers Ethernet padding and FCS remnants.
- Truncation: rx_payload_ipv4 falls in HDR/OPT after byte 0, or in DATA with remaining>0.
  - Response: next cycle rx_pkt_drop=1, code 6. rx_data_last is never asserted for that packet.
- Drop codes: 1 header format, 2 checksum, 3 address, 4 fragment, 5 protocol, 6 truncated.
- Back-to-back frames: a single idle cycle between frames is sufficient. No bubble is required after rx_data_last.
- Outputs rx_data_valid, rx_data_last, rx_hdr_ok and rx_pkt_drop are registered pulses; all default to 0 each cycle.

Test Plan:
- UDP unicast: ip_addr=C0A8010A, IHL=5, total_len=0x0020, proto 0x11, correct checksum, 12 payload bytes 0x00–0x0B → rx_hdr_ok once, rx_pay_len=0x000C, 12 cycles rx_data_valid=2'b01 with data 0x00–0x0B, rx_data_last on 0x0B, rx_src_ip correct.
- TCP with options: IHL=6, 4 option bytes, total_len=0x001C, proto 0x06 → options skipped and covered by the checksum, 4 bytes with rx_data_valid=2'b10, last on the 4th.
- Padding: total_len=0x001C, IHL=5, frame of 46 bytes → exactly 8 data bytes out, 18 discarded, no drop.
- Rejections:
  - Checksum flipped by 1 → rx_pkt_drop, code 2, no data.
  - dst=C0A8010B → code 3.
  - MF set → code 4.
  - proto 0x01 → code 5.
  - dst=FFFFFFFF with ACCEPT_BCAST=1 → accepted.
- Truncation: valid falls after 5 of 12 payload bytes → 5 data bytes, no last, rx_pkt_drop code 6. The next frame, after one idle cycle, is parsed correctly.
- Reset: rst_n low for 1 cycle mid-payload → all outputs 0 next cycle, no drop pulse, rest of frame ignored, following frame accepted.
